// File: rtl/mcu_pkg.sv
// Shared MCU definitions: loader state encoding, default frame marker and
// program-memory address width.
package mcu_pkg;

    localparam int ADDR_W = 8;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_SYNC,
        LS_LEN,
        LS_DATA,
        LS_CSUM,
        LS_DONE,
        LS_ERR
    } loader_state_t;

    // States in which the loader is receiving a frame
    function automatic logic ls_receiving(loader_state_t s);
        return s inside {LS_SYNC, LS_LEN, LS_DATA, LS_CSUM};
    endfunction

    // States guarded by the inter-byte idle timeout
    function automatic logic ls_timed(loader_state_t s);
        return s inside {LS_LEN, LS_DATA, LS_CSUM};
    endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-cycle counter for the program loader; tc_o flags the cycle whose edge
// would bring the count to TIMEOUT.
module loader_timeout_counter #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Clear has priority so a byte accepted in the terminal cycle cancels it
    assign tc_o = en_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: keeps the core halted, streams a framed image into
// program memory and releases the core only when the checksum matches.
module prog_loader
    import mcu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
    parameter logic [7:0]        SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int                TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_halt,
    output logic              busy,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic              rx_ready_q, mem_we_q, core_halt_q, busy_q, done_q, error_q;
    logic [ADDR_W-1:0] mem_addr_q, addr_q;
    logic [7:0]        mem_wdata_q, remain_q, sum_q;
    logic              hs, data_hs, tmo;

    assign hs      = rx_valid && rx_ready_q;
    assign data_hs = hs && (state_q == LS_DATA);

    loader_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk_i (clk),
        .rst_ni(reset),
        .clr_i (hs || !ls_timed(state_q)),
        .en_i  (ls_timed(state_q)),
        .tc_o  (tmo)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LS_IDLE: if (start) state_d = LS_SYNC;
            LS_SYNC: if (hs && rx_data == SYNC_BYTE) state_d = LS_LEN;
            LS_LEN: begin
                if (hs)       state_d = (rx_data == 8'h00) ? LS_ERR : LS_DATA;
                else if (tmo) state_d = LS_ERR;
            end
            LS_DATA: begin
                if (hs)       state_d = (remain_q == 8'd1) ? LS_CSUM : LS_DATA;
                else if (tmo) state_d = LS_ERR;
            end
            LS_CSUM: begin
                if (hs)       state_d = (rx_data == sum_q) ? LS_DONE : LS_ERR;
                else if (tmo) state_d = LS_ERR;
            end
            LS_DONE, LS_ERR: if (start) state_d = LS_SYNC;
            default: state_d = LS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LS_IDLE;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 8'h00;
            core_halt_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_q      <= BASE_ADDR;
            remain_q    <= 8'h00;
            sum_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= ls_receiving(state_d);
            busy_q     <= ls_receiving(state_d);
            mem_we_q   <= data_hs;

            if (state_q == LS_LEN && hs) begin
                remain_q <= rx_data;
                sum_q    <= 8'h00;
                addr_q   <= BASE_ADDR;
            end

            if (data_hs) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= rx_data;
                sum_q       <= sum_q + rx_data;
                addr_q      <= addr_q + 1'b1;
                remain_q    <= remain_q - 1'b1;
            end

            // Status flags move only on state entry
            if (state_d != state_q) begin
                case (state_d)
                    LS_SYNC: begin
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        core_halt_q <= 1'b1;
                    end
                    LS_DONE: begin
                        done_q      <= 1'b1;
                        core_halt_q <= 1'b0;
                    end
                    LS_ERR: begin
                        error_q     <= 1'b1;
                        core_halt_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_halt = core_halt_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 00 and base FE) fed the same
// randomized byte stream and compared against a frame-level reference model.
module tb_prog_loader;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       rdy0, we0, halt0, busy0, done0, err0;
    logic [7:0] addr0, wd0;
    logic       rdy1, we1, halt1, busy1, done1, err1;
    logic [7:0] addr1, wd1;

    int checks = 0;
    int errors = 0;

    logic [15:0] cap0[$];
    logic [15:0] cap1[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_data[$];
    bit          exp_ok;

    prog_loader #(.BASE_ADDR(8'h00), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .core_halt(halt0), .busy(busy0), .done(done0), .error(err0)
    );

    prog_loader #(.BASE_ADDR(8'hFE), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut_fe (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .core_halt(halt1), .busy(busy1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we0) cap0.push_back({addr0, wd0});
        if (we1) cap1.push_back({addr1, wd1});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: parse the frame by its rules, giving data bytes and outcome
    task automatic model_frame();
        int i, n, sum;
        exp_data.delete();
        i = 0;
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        n = int'(frame_q[i+1]);
        if (n == 0) begin
            exp_ok = 1'b0;
            return;
        end
        sum = 0;
        for (int k = 0; k < n; k++) begin
            exp_data.push_back(frame_q[i+2+k]);
            sum = sum + int'(frame_q[i+2+k]);
        end
        exp_ok = (int'(frame_q[i+2+n]) == (sum % 256));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit st);
        int gap, n;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = st;
        n = 0;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        checks++;
        if (!rdy0) begin
            errors++;
            $display("FAIL handshake_wait: rx_ready=%0b required 1", rdy0);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({rdy0, rdy1, busy0, halt0, done0, err0} !== 6'b111100) begin
            errors++;
            $display("FAIL start_sync: rdy/rdy/busy/halt/done/err=%b required 111100",
                     {rdy0, rdy1, busy0, halt0, done0, err0});
        end
    endtask

    task automatic run_frame(input string name, input bit poke_start);
        model_frame();
        do_start();
        cap0.delete();
        cap1.delete();
        foreach (frame_q[i]) send_byte(frame_q[i], poke_start && (i == 0));
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({done0, err0, halt0, busy0, rdy0} !== {exp_ok, !exp_ok, !exp_ok, 2'b00}) begin
            errors++;
            $display("FAIL %s status: done/err/halt/busy/rdy=%b required %b", name,
                     {done0, err0, halt0, busy0, rdy0}, {exp_ok, !exp_ok, !exp_ok, 2'b00});
        end
        checks++;
        if ({done1, err1, halt1} !== {exp_ok, !exp_ok, !exp_ok}) begin
            errors++;
            $display("FAIL %s status_fe: done/err/halt=%b required %b", name,
                     {done1, err1, halt1}, {exp_ok, !exp_ok, !exp_ok});
        end
        checks++;
        if (cap0.size() != exp_data.size() || cap1.size() != exp_data.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d/%0d required %0d", name,
                     cap0.size(), cap1.size(), exp_data.size());
        end else begin
            foreach (exp_data[k]) begin
                checks++;
                if (cap0[k] !== {8'(k), exp_data[k]} || cap1[k] !== {8'(254 + k), exp_data[k]}) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got %h/%h required %h/%h", name, k,
                             cap0[k], cap1[k], {8'(k), exp_data[k]}, {8'(254 + k), exp_data[k]});
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy0, we0, addr0, wd0, halt0, busy0, done0, err0} !== {2'b00, 8'h00, 8'h00, 4'b1000}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h",
                     {rdy0, we0, addr0, wd0, halt0, busy0, done0, err0}, {2'b00, 8'h00, 8'h00, 4'b1000});
        end
        checks++;
        if (addr1 !== 8'hFE) begin
            errors++;
            $display("FAIL reset_addr_fe: got %h required fe", addr1);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy0, busy0, halt0} !== 3'b001) begin
            errors++;
            $display("FAIL idle_after_reset: rdy/busy/halt=%b required 001", {rdy0, busy0, halt0});
        end
    endtask

    task automatic test_directed();
        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame("good_frame", 1'b0);
        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
        run_frame("bad_csum", 1'b0);
        frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h7F};
        run_frame("noise_prefix", 1'b1);
        frame_q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
        run_frame("addr_wrap", 1'b0);
        frame_q = '{8'hA5, 8'h00};
        run_frame("len_zero", 1'b0);
    endtask

    task automatic test_timeout();
        do_start();
        cap0.delete();
        cap1.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: error=%0b required 0", err0);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h03;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if ({err0, rdy0} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_handshake_wins: err/rdy=%b required 01", {err0, rdy0});
        end
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if ({err0, busy0} !== 2'b01) begin
            errors++;
            $display("FAIL tmo_before_limit: err/busy=%b required 01", {err0, busy0});
        end
        @(negedge clk);
        checks++;
        if ({err0, halt0, busy0, rdy0, done0, err1} !== 6'b110001) begin
            errors++;
            $display("FAIL tmo_expired: err/halt/busy/rdy/done/err_fe=%b required 110001",
                     {err0, halt0, busy0, rdy0, done0, err1});
        end
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (cap0.size() != 3 || cap1.size() != 3) begin
            errors++;
            $display("FAIL tmo_writes: got %0d/%0d required 3", cap0.size(), cap1.size());
        end else begin
            checks++;
            if (cap0[2] !== 16'h0203 || cap1[2] !== 16'h0003) begin
                errors++;
                $display("FAIL tmo_last_write: got %h/%h required 0203/0003", cap0[2], cap1[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        cap0.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({rdy0, we0, addr0, wd0, halt0, busy0, done0, err0, addr1} !==
            {2'b00, 8'h00, 8'h00, 4'b1000, 8'hFE}) begin
            errors++;
            $display("FAIL reset_mid: got %h required %h",
                     {rdy0, we0, addr0, wd0, halt0, busy0, done0, err0, addr1},
                     {2'b00, 8'h00, 8'h00, 4'b1000, 8'hFE});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (cap0.size() != 2 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: writes=%0d busy=%0b required 2 and 0", cap0.size(), busy0);
        end
        frame_q = '{8'hA5, 8'h02, 8'hC0, 8'h41, 8'h01};
        run_frame("after_reset", 1'b0);
    endtask

    task automatic test_random();
        int n, noise, sum;
        logic [7:0] b;
        for (int r = 0; r < 10; r++) begin
            frame_q.delete();
            noise = $urandom_range(0, 3);
            for (int k = 0; k < noise; k++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                frame_q.push_back(b);
            end
            n = $urandom_range(1, 12);
            frame_q.push_back(8'hA5);
            frame_q.push_back(8'(n));
            sum = 0;
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                sum += int'(b);
                frame_q.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) frame_q.push_back(8'(sum + int'($urandom_range(1, 255))));
            else frame_q.push_back(8'(sum));
            run_frame("random", 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
